// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: drives the data-memory req/ack handshake for loads and
// stores, stalls the front of the pipeline while an access is in flight, and registers MEM/WB.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_read_i,
  input  logic       mem_write_i,
  input  logic       mem_to_reg_i,
  input  logic       reg_write_i,
  input  logic [7:0] store_data_i,
  input  logic [7:0] alu_out_i,
  input  logic [2:0] reg_dst_i,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic [7:0] dmem_addr,
  output logic [7:0] dmem_wdata,
  input  logic [7:0] dmem_rdata,
  input  logic       dmem_ack,
  output logic       stall,
  output logic       wb_mem_to_reg,
  output logic       wb_reg_write,
  output logic [7:0] wb_read_data,
  output logic [7:0] wb_alu_out,
  output logic [2:0] wb_reg_dst,
  output logic       mem_err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          latMemToReg;
  logic          latRegWrite;
  logic [2:0]    latRegDst;
  logic          access;
  logic          timeoutHit;

  assign access     = mem_read_i | mem_write_i;
  assign timeoutHit = (TIMEOUT > 0) && (cnt == CW'(TIMEOUT - 1));
  assign stall      = ((state == IDLE) && access) || (state == ACCESS);

  // dmem_addr/dmem_wdata/dmem_we double as the latched address, store data and
  // access type; they are held untouched for the whole access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      latMemToReg   <= 1'b0;
      latRegWrite   <= 1'b0;
      latRegDst     <= '0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      wb_mem_to_reg <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_read_data  <= '0;
      wb_alu_out    <= '0;
      wb_reg_dst    <= '0;
      mem_err       <= 1'b0;
    end else begin
      // bubble unless a branch below publishes an instruction
      wb_mem_to_reg <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_read_data  <= '0;
      wb_alu_out    <= '0;
      wb_reg_dst    <= '0;
      case (state)
        IDLE: begin
          if (access) begin
            latMemToReg <= mem_to_reg_i;
            latRegWrite <= reg_write_i;
            latRegDst   <= reg_dst_i;
            dmem_req    <= 1'b1;
            dmem_we     <= mem_write_i;
            dmem_addr   <= alu_out_i;
            dmem_wdata  <= store_data_i;
            cnt         <= '0;
            state       <= ACCESS;
          end else begin
            wb_mem_to_reg <= mem_to_reg_i;
            wb_reg_write  <= reg_write_i;
            wb_alu_out    <= alu_out_i;
            wb_reg_dst    <= reg_dst_i;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            dmem_req      <= 1'b0;
            wb_mem_to_reg <= latMemToReg;
            wb_reg_write  <= latRegWrite;
            wb_read_data  <= dmem_we ? 8'h00 : dmem_rdata;
            wb_alu_out    <= dmem_addr;
            wb_reg_dst    <= latRegDst;
            state         <= DONE;
          end else if (timeoutHit) begin
            // aborted load must not write the register file
            dmem_req      <= 1'b0;
            mem_err       <= 1'b1;
            wb_mem_to_reg <= latMemToReg;
            wb_alu_out    <= dmem_addr;
            wb_reg_dst    <= latRegDst;
            state         <= DONE;
          end else if (cnt != {CW{1'b1}}) begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed table-driven bench for mem_stage_ctrl (TIMEOUT=4): passthrough, load,
// store, read+write, ack at the timeout boundary, timeout, stray ack, mid-access reset.
module tb_mem_stage_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i;
  logic [7:0] store_data_i, alu_out_i;
  logic [2:0] reg_dst_i;
  logic       dmem_req, dmem_we;
  logic [7:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic       dmem_ack;
  logic       stall, wb_mem_to_reg, wb_reg_write;
  logic [7:0] wb_read_data, wb_alu_out;
  logic [2:0] wb_reg_dst;
  logic       mem_err;

  int checks = 0;
  int errors = 0;
  int curVec = -1;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .mem_to_reg_i(mem_to_reg_i), .reg_write_i(reg_write_i),
    .store_data_i(store_data_i), .alu_out_i(alu_out_i), .reg_dst_i(reg_dst_i),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall), .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
    .wb_read_data(wb_read_data), .wb_alu_out(wb_alu_out), .wb_reg_dst(wb_reg_dst),
    .mem_err(mem_err)
  );

  typedef struct {
    logic       rd, wr, m2r, rw;
    logic [7:0] sd, alu;
    logic [2:0] dst;
    logic       ack;
    logic [7:0] rdata;
    logic       eStall, eReq, eWe;
    logic [7:0] eAddr, eWdata;
    logic       eM2r, eRw;
    logic [7:0] eRd, eAlu;
    logic [2:0] eDst;
    logic       eErr;
  } vec_t;

  function automatic vec_t mk(
    input logic rd, wr, m2r, rw, input logic [7:0] sd, alu, input logic [2:0] dst,
    input logic ack, input logic [7:0] rdata,
    input logic eStall, eReq, eWe, input logic [7:0] eAddr, eWdata,
    input logic eM2r, eRw, input logic [7:0] eRd, eAlu, input logic [2:0] eDst,
    input logic eErr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.m2r = m2r; v.rw = rw; v.sd = sd; v.alu = alu;
    v.dst = dst; v.ack = ack; v.rdata = rdata;
    v.eStall = eStall; v.eReq = eReq; v.eWe = eWe; v.eAddr = eAddr;
    v.eWdata = eWdata; v.eM2r = eM2r; v.eRw = eRw; v.eRd = eRd;
    v.eAlu = eAlu; v.eDst = eDst; v.eErr = eErr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%h want=%h", nm, curVec, act, exp);
    end
  endtask

  task automatic drive(input logic rd, wr, m2r, rw, input logic [7:0] sd, alu,
                       input logic [2:0] dst, input logic ack, input logic [7:0] rdata);
    mem_read_i = rd; mem_write_i = wr; mem_to_reg_i = m2r; reg_write_i = rw;
    store_data_i = sd; alu_out_i = alu; reg_dst_i = dst;
    dmem_ack = ack; dmem_rdata = rdata;
  endtask

  task automatic chkWbZero(input string tag);
    chk({tag, "_wb_m2r"}, {7'd0, wb_mem_to_reg}, 8'h00);
    chk({tag, "_wb_rw"},  {7'd0, wb_reg_write},  8'h00);
    chk({tag, "_wb_rd"},  wb_read_data,          8'h00);
    chk({tag, "_wb_alu"}, wb_alu_out,            8'h00);
    chk({tag, "_wb_dst"}, {5'd0, wb_reg_dst},    8'h00);
  endtask

  vec_t vecs[$];

  initial begin
    // passthrough
    vecs.push_back(mk(0,0,0,1,8'h00,8'h3C,3'd5,0,8'h00, 0,0,0,8'h00,8'h00, 0,1,8'h00,8'h3C,3'd5,0));
    // load @10, ack on 3rd ACCESS cycle
    vecs.push_back(mk(1,0,1,1,8'h00,8'h10,3'd2,0,8'hA5, 1,1,0,8'h10,8'h00, 0,0,8'h00,8'h00,3'd0,0));
    vecs.push_back(mk(1,0,1,1,8'h00,8'h10,3'd2,0,8'hA5, 1,1,0,8'h10,8'h00, 0,0,8'h00,8'h00,3'd0,0));
    vecs.push_back(mk(1,0,1,1,8'h00,8'h10,3'd2,0,8'hA5, 1,1,0,8'h10,8'h00, 0,0,8'h00,8'h00,3'd0,0));
    vecs.push_back(mk(1,0,1,1,8'h00,8'h10,3'd2,1,8'hA5, 1,0,0,8'h00,8'h00, 1,1,8'hA5,8'h10,3'd2,0));
    vecs.push_back(mk(1,0,1,1,8'h00,8'h10,3'd2,0,8'hA5, 0,0,0,8'h00,8'h00, 0,0,8'h00,8'h00,3'd0,0));
    // next instruction with a stray ack in IDLE
    vecs.push_back(mk(0,0,0,1,8'h00,8'h55,3'd3,1,8'hEE, 0,0,0,8'h00,8'h00, 0,1,8'h00,8'h55,3'd3,0));
    // store @20 data 7E, ack on 1st ACCESS cycle
    vecs.push_back(mk(0,1,0,0,8'h7E,8'h20,3'd0,0,8'h00, 1,1,1,8'h20,8'h7E, 0,0,8'h00,8'h00,3'd0,0));
    vecs.push_back(mk(0,1,0,0,8'h7E,8'h20,3'd0,1,8'h00, 1,0,0,8'h00,8'h00, 0,0,8'h00,8'h20,3'd0,0));
    vecs.push_back(mk(0,1,0,0,8'h7E,8'h20,3'd0,0,8'h00, 0,0,0,8'h00,8'h00, 0,0,8'h00,8'h00,3'd0,0));
    // read and write together -> write, no load data
    vecs.push_back(mk(1,1,0,0,8'h11,8'h30,3'd1,0,8'hFF, 1,1,1,8'h30,8'h11, 0,0,8'h00,8'h00,3'd0,0));
    vecs.push_back(mk(1,1,0,0,8'h11,8'h30,3'd1,1,8'hFF, 1,0,0,8'h00,8'h00, 0,0,8'h00,8'h30,3'd1,0));
    vecs.push_back(mk(1,1,0,0,8'h11,8'h30,3'd1,0,8'hFF, 0,0,0,8'h00,8'h00, 0,0,8'h00,8'h00,3'd0,0));
    // ack arrives exactly when the counter reaches TIMEOUT-1
    vecs.push_back(mk(1,0,1,1,8'h00,8'h40,3'd4,0,8'hC3, 1,1,0,8'h40,8'h00, 0,0,8'h00,8'h00,3'd0,0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1,0,1,1,8'h00,8'h40,3'd4,0,8'hC3, 1,1,0,8'h40,8'h00, 0,0,8'h00,8'h00,3'd0,0));
    vecs.push_back(mk(1,0,1,1,8'h00,8'h40,3'd4,1,8'hC3, 1,0,0,8'h00,8'h00, 1,1,8'hC3,8'h40,3'd4,0));
    vecs.push_back(mk(1,0,1,1,8'h00,8'h40,3'd4,0,8'hC3, 0,0,0,8'h00,8'h00, 0,0,8'h00,8'h00,3'd0,0));
    // timeout: no ack for 4 ACCESS cycles
    vecs.push_back(mk(1,0,1,1,8'h00,8'h50,3'd6,0,8'h99, 1,1,0,8'h50,8'h00, 0,0,8'h00,8'h00,3'd0,0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1,0,1,1,8'h00,8'h50,3'd6,0,8'h99, 1,1,0,8'h50,8'h00, 0,0,8'h00,8'h00,3'd0,0));
    vecs.push_back(mk(1,0,1,1,8'h00,8'h50,3'd6,0,8'h99, 1,0,0,8'h00,8'h00, 1,0,8'h00,8'h50,3'd6,1));
    vecs.push_back(mk(1,0,1,1,8'h00,8'h50,3'd6,0,8'h99, 0,0,0,8'h00,8'h00, 0,0,8'h00,8'h00,3'd0,1));
    vecs.push_back(mk(0,0,0,1,8'h00,8'h77,3'd1,0,8'h00, 0,0,0,8'h00,8'h00, 0,1,8'h00,8'h77,3'd1,1));

    // reset state
    drive(0,0,0,0,8'h00,8'h00,3'd0,0,8'h00);
    rst = 1'b1;
    #12;
    chk("rst_req",   {7'd0, dmem_req}, 8'h00);
    chk("rst_stall", {7'd0, stall},    8'h00);
    chk("rst_err",   {7'd0, mem_err},  8'h00);
    chkWbZero("rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      curVec = i;
      drive(vecs[i].rd, vecs[i].wr, vecs[i].m2r, vecs[i].rw, vecs[i].sd,
            vecs[i].alu, vecs[i].dst, vecs[i].ack, vecs[i].rdata);
      #1;
      chk("stall", {7'd0, stall}, {7'd0, vecs[i].eStall});
      @(posedge clk); #1;
      chk("dmem_req", {7'd0, dmem_req}, {7'd0, vecs[i].eReq});
      if (vecs[i].eReq) begin
        chk("dmem_we",    {7'd0, dmem_we}, {7'd0, vecs[i].eWe});
        chk("dmem_addr",  dmem_addr,       vecs[i].eAddr);
        chk("dmem_wdata", dmem_wdata,      vecs[i].eWdata);
      end
      chk("wb_mem_to_reg", {7'd0, wb_mem_to_reg}, {7'd0, vecs[i].eM2r});
      chk("wb_reg_write",  {7'd0, wb_reg_write},  {7'd0, vecs[i].eRw});
      chk("wb_read_data",  wb_read_data,          vecs[i].eRd);
      chk("wb_alu_out",    wb_alu_out,            vecs[i].eAlu);
      chk("wb_reg_dst",    {5'd0, wb_reg_dst},    {5'd0, vecs[i].eDst});
      chk("mem_err",       {7'd0, mem_err},       {7'd0, vecs[i].eErr});
    end

    // async reset in the middle of an access; mem_err (set above) must clear
    curVec = 100;
    drive(1,0,1,1,8'h00,8'h60,3'd7,0,8'h12);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_req_pre", {7'd0, dmem_req}, 8'h01);
    rst = 1'b1;
    drive(0,0,0,0,8'h00,8'h00,3'd0,0,8'h00);
    #1;
    chk("mid_req",   {7'd0, dmem_req}, 8'h00);
    chk("mid_stall", {7'd0, stall},    8'h00);
    chk("mid_err",   {7'd0, mem_err},  8'h00);
    chkWbZero("mid");
    #2;
    rst = 1'b0;
    // late ack for the dropped request lands in IDLE
    dmem_ack = 1'b1;
    dmem_rdata = 8'h12;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("late_ack_req",   {7'd0, dmem_req}, 8'h00);
    chk("late_ack_stall", {7'd0, stall},    8'h00);
    chkWbZero("late_ack");
    // block still serves a fresh load afterwards
    drive(1,0,1,1,8'h00,8'h61,3'd2,0,8'h00);
    @(posedge clk); #1;
    chk("post_req",  {7'd0, dmem_req}, 8'h01);
    chk("post_addr", dmem_addr,        8'h61);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
